// File: rtl/ibert_pkg.sv
// Shared types and default widths for the IBERT phase sequencer and its accumulator.
package ibert_pkg;

  localparam int ERR_W = 13;
  localparam int ACC_W = 32;
  localparam int WIN_W = 25;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_REPORT  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic [2:0]        ctrl_sig;
    logic [2:0]        val;
    logic signed [2:0] taps;
    logic [WIN_W-1:0]  window;
  } phase_cfg_t;

endpackage

// File: rtl/ibert_sat_acc.sv
// Saturating error accumulator and measured-cycle counter for one BER phase.
module ibert_sat_acc #(
  parameter int ERR_W = 13,
  parameter int ACC_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [ERR_W-1:0] err_i,
  output logic [ACC_W-1:0] errors_o,
  output logic [ACC_W-1:0] cycles_o
);

  // One spare bit above the wider operand so the overflow compare cannot wrap.
  localparam int SUM_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

  logic [ACC_W-1:0] errors_q, errors_d;
  logic [ACC_W-1:0] cycles_q, cycles_d;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] max_v;

  assign sum   = SUM_W'(errors_q) + SUM_W'(err_i);
  assign max_v = SUM_W'({ACC_W{1'b1}});

  always_comb begin
    errors_d = errors_q;
    cycles_d = cycles_q;
    if (clr_i) begin
      errors_d = '0;
      cycles_d = '0;
    end else if (en_i) begin
      errors_d = (sum > max_v) ? '1 : sum[ACC_W-1:0];
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      errors_q <= '0;
      cycles_q <= '0;
    end else begin
      errors_q <= errors_d;
      cycles_q <= cycles_d;
    end
  end

  assign errors_o = errors_q;
  assign cycles_o = cycles_q;

endmodule

// File: rtl/ibert_test_sequencer.sv
// Steps through a programmed table of BER test phases: load, settle, measure, report.
//   state     | meaning
//   S_IDLE    | table writable, waiting for start
//   S_LOAD    | drive phase config, reload strobe, clear accumulator
//   S_SETTLE  | wait SETTLE cycles, errors ignored
//   S_MEASURE | accumulate errors for max(window,1) cycles
//   S_REPORT  | present result, advance phase or finish
module ibert_test_sequencer import ibert_pkg::*; #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_AW   = 2,
  parameter int ERR_W      = ibert_pkg::ERR_W,
  parameter int ACC_W      = ibert_pkg::ACC_W,
  parameter int SETTLE     = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [PHASE_AW:0]   num_phases,
  input  logic                cfg_we,
  input  logic [PHASE_AW-1:0] cfg_addr,
  input  logic [2:0]          cfg_ctrl_sig,
  input  logic [2:0]          cfg_val,
  input  logic [2:0]          cfg_taps,
  input  logic [24:0]         cfg_window,
  output logic                dut_control,
  output logic                dut_sel,
  output logic [2:0]          dut_ctrl_sig,
  output logic [2:0]          dut_val,
  output logic [2:0]          dut_taps,
  output logic [24:0]         dut_wanted_cl_val,
  input  logic [ERR_W-1:0]    dut_error,
  output logic                busy,
  output logic                done,
  output logic                res_valid,
  output logic [PHASE_AW-1:0] res_phase,
  output logic [ACC_W-1:0]    res_errors,
  output logic [ACC_W-1:0]    res_cycles
);

  seq_state_t          state_q, state_d;
  phase_cfg_t          table_q [NUM_PHASES];
  phase_cfg_t          cur_q, cur_d;
  logic [PHASE_AW-1:0] phase_q, phase_d;
  logic [PHASE_AW:0]   nph_q, nph_d, nph_clamp;
  logic [WIN_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [PHASE_AW-1:0] res_phase_q;
  logic [ACC_W-1:0]    res_errors_q, res_cycles_q;
  logic [ACC_W-1:0]    acc_errors, acc_cycles;
  logic                last_phase;
  logic                report_ok;

  assign nph_clamp  = (num_phases > (PHASE_AW+1)'(NUM_PHASES)) ? (PHASE_AW+1)'(NUM_PHASES) : num_phases;
  assign last_phase = (({1'b0, phase_q} + 1'b1) == nph_q);
  assign report_ok  = (state_q == S_REPORT) && !abort;

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start && (nph_clamp != '0)) state_d = S_LOAD;
      S_LOAD:    state_d = S_SETTLE;
      S_SETTLE:  if (cnt_q == '0) state_d = S_MEASURE;
      S_MEASURE: if (cnt_q == '0) state_d = S_REPORT;
      S_REPORT:  state_d = last_phase ? S_IDLE : S_LOAD;
      default:   state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  always_comb begin
    phase_d = phase_q;
    nph_d   = nph_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if ((state_q == S_IDLE) && start) begin
      phase_d = '0;
      nph_d   = nph_clamp;
      done_d  = (nph_clamp == '0);
    end
    if (report_ok) begin
      phase_d = phase_q + 1'b1;
      done_d  = last_phase;
    end
    if (state_d == S_LOAD)      cur_d = table_q[phase_d];
    else if (state_d == S_IDLE) cur_d = '0;
    // One timer serves both waits: reloaded on entry to SETTLE and to MEASURE.
    if (state_q == S_LOAD)
      cnt_d = WIN_W'(SETTLE - 1);
    else if ((state_q == S_SETTLE) && (cnt_q == '0))
      cnt_d = (cur_q.window == '0) ? '0 : cur_q.window - 1'b1;
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHASES; i++) table_q[i] <= '0;
      cur_q        <= '0;
      phase_q      <= '0;
      nph_q        <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      res_phase_q  <= '0;
      res_errors_q <= '0;
      res_cycles_q <= '0;
    end else begin
      if ((state_q == S_IDLE) && cfg_we)
        table_q[cfg_addr] <= {cfg_ctrl_sig, cfg_val, cfg_taps, cfg_window};
      cur_q   <= cur_d;
      phase_q <= phase_d;
      nph_q   <= nph_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (report_ok) begin
        res_phase_q  <= phase_q;
        res_errors_q <= acc_errors;
        res_cycles_q <= acc_cycles;
      end
    end
  end

  ibert_sat_acc #(.ERR_W(ERR_W), .ACC_W(ACC_W)) u_acc (
    .clock    (clock),
    .reset    (reset),
    .clr_i    (state_q == S_LOAD),
    .en_i     (state_q == S_MEASURE),
    .err_i    (dut_error),
    .errors_o (acc_errors),
    .cycles_o (acc_cycles)
  );

  // Results read straight from the accumulator in REPORT, then from the held copy.
  always_comb begin
    busy              = (state_q != S_IDLE);
    dut_sel           = busy;
    dut_control       = (state_q == S_LOAD);
    dut_ctrl_sig      = cur_q.ctrl_sig;
    dut_val           = cur_q.val;
    dut_taps          = cur_q.taps;
    dut_wanted_cl_val = cur_q.window;
    done              = done_q;
    res_valid         = report_ok;
    res_phase         = report_ok ? phase_q    : res_phase_q;
    res_errors        = report_ok ? acc_errors : res_errors_q;
    res_cycles        = report_ok ? acc_cycles : res_cycles_q;
  end

endmodule

// File: tb/tb_ibert_test_sequencer.sv
// Directed bench for ibert_test_sequencer: full-width instance plus an 8-bit accumulator instance.
module tb_ibert_test_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  num_phases = '0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [2:0]  cfg_ctrl_sig = '0;
  logic [2:0]  cfg_val = '0;
  logic [2:0]  cfg_taps = '0;
  logic [24:0] cfg_window = '0;
  logic [12:0] err_main = '0;
  logic [12:0] err_sat = '0;

  logic        dut_control, dut_sel, busy, done, res_valid;
  logic [2:0]  dut_ctrl_sig, dut_val, dut_taps;
  logic [24:0] dut_wanted_cl_val;
  logic [1:0]  res_phase;
  logic [31:0] res_errors, res_cycles;

  logic        s_control, s_sel, s_busy, s_done, s_res_valid;
  logic [2:0]  s_ctrl_sig, s_val, s_taps;
  logic [24:0] s_wanted;
  logic [1:0]  s_res_phase;
  logic [7:0]  s_res_errors, s_res_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ibert_test_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .num_phases(num_phases),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_ctrl_sig(cfg_ctrl_sig), .cfg_val(cfg_val),
    .cfg_taps(cfg_taps), .cfg_window(cfg_window), .dut_control(dut_control), .dut_sel(dut_sel),
    .dut_ctrl_sig(dut_ctrl_sig), .dut_val(dut_val), .dut_taps(dut_taps),
    .dut_wanted_cl_val(dut_wanted_cl_val), .dut_error(err_main), .busy(busy), .done(done),
    .res_valid(res_valid), .res_phase(res_phase), .res_errors(res_errors), .res_cycles(res_cycles)
  );

  ibert_test_sequencer #(.ACC_W(8)) dut_sat (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .num_phases(num_phases),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_ctrl_sig(cfg_ctrl_sig), .cfg_val(cfg_val),
    .cfg_taps(cfg_taps), .cfg_window(cfg_window), .dut_control(s_control), .dut_sel(s_sel),
    .dut_ctrl_sig(s_ctrl_sig), .dut_val(s_val), .dut_taps(s_taps),
    .dut_wanted_cl_val(s_wanted), .dut_error(err_sat), .busy(s_busy), .done(s_done),
    .res_valid(s_res_valid), .res_phase(s_res_phase), .res_errors(s_res_errors), .res_cycles(s_res_cycles)
  );

  // Event log, sampled on the falling edge.
  int          cyc = 0;
  int          ev_cnt = 0, ld_cnt = 0, done_cnt = 0, busy_cnt = 0, s_cnt = 0;
  int          ev_cyc [64];
  logic [1:0]  ev_ph  [64];
  logic [31:0] ev_err [64];
  logic [31:0] ev_cy  [64];
  logic [2:0]  ld_ctrl [64];
  logic [2:0]  ld_val  [64];
  logic [2:0]  ld_taps [64];
  int          done_cyc = 0;
  logic [7:0]  s_err = '0, s_cy = '0;

  always @(negedge clock) begin
    cyc++;
    if (res_valid && ev_cnt < 64) begin
      ev_cyc[ev_cnt] = cyc;
      ev_ph[ev_cnt]  = res_phase;
      ev_err[ev_cnt] = res_errors;
      ev_cy[ev_cnt]  = res_cycles;
      ev_cnt++;
    end
    if (dut_control && ld_cnt < 64) begin
      ld_ctrl[ld_cnt] = dut_ctrl_sig;
      ld_val[ld_cnt]  = dut_val;
      ld_taps[ld_cnt] = dut_taps;
      ld_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_cnt++;
    if (s_res_valid) begin
      s_err = s_res_errors;
      s_cy  = s_res_cycles;
      s_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic write_phase(input logic [1:0] a, input logic [2:0] cs, input logic [2:0] v,
                             input logic [2:0] tp, input logic [24:0] w);
    cfg_we = 1'b1; cfg_addr = a; cfg_ctrl_sig = cs; cfg_val = v; cfg_taps = tp; cfg_window = w;
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic run(input logic [2:0] n);
    num_phases = n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, input string tag);
    int k = 0;
    while (done_cnt <= base && k < 600) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(done_cnt > base), 64'd1);
  endtask

  task automatic wait_res(input int base, input string tag);
    int k = 0;
    while (ev_cnt <= base && k < 600) begin
      tick(1);
      k++;
    end
    chk(tag, 64'(ev_cnt > base), 64'd1);
  endtask

  initial begin
    int eb, db, lb, bb, sb;

    tick(2);
    chk("rst_ctrl_outs", 64'(|{busy, dut_sel, dut_control, dut_ctrl_sig, dut_val, dut_taps, dut_wanted_cl_val, done}), 64'd0);
    chk("rst_res_outs", 64'(|{res_valid, res_phase, res_errors, res_cycles}), 64'd0);
    reset = 1'b0;
    tick(1);

    // Three phases, window 20, one error per cycle.
    write_phase(2'd0, 3'd1, 3'd7, 3'b110, 25'd20);
    write_phase(2'd1, 3'd2, 3'd7, 3'b110, 25'd20);
    write_phase(2'd2, 3'd3, 3'd7, 3'b110, 25'd20);
    write_phase(2'd3, 3'd6, 3'd1, 3'b001, 25'd5);
    err_main = 13'd1; err_sat = 13'd1;
    eb = ev_cnt; db = done_cnt; lb = ld_cnt;
    run(3'd3);
    chk("t1_busy_after_start", 64'(busy), 64'd1);
    chk("t1_control_first_load", 64'(dut_control), 64'd1);
    wait_done(db, "t1_done_timeout");
    chk("t1_num_results", 64'(ev_cnt - eb), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t1_phase%0d", i), 64'(ev_ph[eb+i]), 64'(i));
      chk($sformatf("t1_errors%0d", i), 64'(ev_err[eb+i]), 64'd20);
      chk($sformatf("t1_cycles%0d", i), 64'(ev_cy[eb+i]), 64'd20);
      chk($sformatf("t1_ld_ctrl%0d", i), 64'(ld_ctrl[lb+i]), 64'(i + 1));
    end
    chk("t1_ld_val", 64'(ld_val[lb]), 64'd7);
    chk("t1_ld_taps", 64'(ld_taps[lb]), 64'b110);
    chk("t1_report_spacing", 64'(ev_cyc[eb+1] - ev_cyc[eb]), 64'd30);
    chk("t1_done_latency", 64'(done_cyc - ev_cyc[eb+2]), 64'd1);
    chk("t1_busy_at_done", 64'(busy), 64'd0);
    chk("t1_cfg_cleared_idle", 64'(dut_wanted_cl_val), 64'd0);
    chk("t1_res_held", 64'(res_errors), 64'd20);

    // Zero window measures exactly one cycle.
    write_phase(2'd0, 3'd4, 3'd0, 3'd0, 25'd0);
    err_main = 13'd5;
    eb = ev_cnt; db = done_cnt;
    run(3'd1);
    wait_done(db, "t2_done_timeout");
    chk("t2_cycles", 64'(ev_cy[eb]), 64'd1);
    chk("t2_errors", 64'(ev_err[eb]), 64'd5);

    // 8-bit accumulator saturates.
    write_phase(2'd0, 3'd1, 3'd0, 3'd0, 25'd4);
    err_main = 13'd1; err_sat = 13'd8191;
    eb = ev_cnt; db = done_cnt; sb = s_cnt;
    run(3'd1);
    wait_done(db, "t3_done_timeout");
    chk("t3_sat_results", 64'(s_cnt - sb), 64'd1);
    chk("t3_sat_errors", 64'(s_err), 64'd255);
    chk("t3_sat_cycles", 64'(s_cy), 64'd4);
    chk("t3_main_errors", 64'(ev_err[eb]), 64'd4);

    // Abort on third MEASURE cycle of phase 1.
    write_phase(2'd0, 3'd1, 3'd7, 3'b110, 25'd20);
    eb = ev_cnt; db = done_cnt;
    run(3'd3);
    wait_res(eb, "t4_first_result_timeout");
    tick(12);
    chk("t4_busy_before_abort", 64'(busy), 64'd1);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t4_busy_after_abort", 64'(busy), 64'd0);
    chk("t4_cfg_after_abort", 64'(|{dut_sel, dut_ctrl_sig, dut_val, dut_taps, dut_wanted_cl_val}), 64'd0);
    tick(100);
    chk("t4_no_more_results", 64'(ev_cnt - eb), 64'd1);
    chk("t4_no_done", 64'(done_cnt - db), 64'd0);

    // num_phases=0 completes immediately without going busy.
    eb = ev_cnt; db = done_cnt; bb = busy_cnt;
    run(3'd0);
    chk("t5_done_pulse", 64'(done), 64'd1);
    tick(4);
    chk("t5_never_busy", 64'(busy_cnt - bb), 64'd0);
    chk("t5_single_done", 64'(done_cnt - db), 64'd1);
    chk("t5_no_result", 64'(ev_cnt - eb), 64'd0);

    // Table writes during a run are dropped.
    write_phase(2'd0, 3'd2, 3'd3, 3'd1, 25'd3);
    db = done_cnt;
    run(3'd1);
    tick(4);
    write_phase(2'd0, 3'd5, 3'd5, 3'd5, 25'd9);
    wait_done(db, "t5b_first_done_timeout");
    eb = ev_cnt; db = done_cnt; lb = ld_cnt;
    run(3'd1);
    wait_done(db, "t5b_rerun_done_timeout");
    chk("t5b_ld_ctrl", 64'(ld_ctrl[lb]), 64'd2);
    chk("t5b_cycles", 64'(ev_cy[eb]), 64'd3);

    // Reset during SETTLE, then rerun on the cleared table.
    write_phase(2'd0, 3'd4, 3'd1, 3'd1, 25'd10);
    lb = ld_cnt;
    run(3'd1);
    while (ld_cnt <= lb && cyc < 90000) tick(1);
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("t6_rst_ctrl_outs", 64'(|{busy, dut_sel, dut_control, dut_ctrl_sig, dut_val, dut_taps, dut_wanted_cl_val, done}), 64'd0);
    chk("t6_rst_res_outs", 64'(|{res_valid, res_phase, res_errors, res_cycles}), 64'd0);
    reset = 1'b0;
    err_main = 13'd3;
    eb = ev_cnt; db = done_cnt; lb = ld_cnt;
    run(3'd1);
    wait_done(db, "t6_done_timeout");
    chk("t6_ld_ctrl", 64'(ld_ctrl[lb]), 64'd0);
    chk("t6_errors", 64'(ev_err[eb]), 64'd3);
    chk("t6_cycles", 64'(ev_cy[eb]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
